spi_frame_ctrl: RTL and testbench
=================================

Name: spi_frame_ctrl

Overview:
- Downstream consumer of the input-conditioner stage in the SPI peripheral.
- Takes conditioned CS/MOSI levels and one-cycle SCLK edge pulses, and assembles SPI mode-0 frames: command byte (address MSB-first, then R/W), then one data byte.
- Drives the register-file port (address, write data, write strobe) and the MISO output with its output enable.

Parameters:
ADDR_W, 7, address width; command length = ADDR_W+1 bits
DATA_W, 8, data width; data phase length in SCLK rises

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sclk_rise  input  1  one-cycle pulse, conditioned SCLK rising edge
sclk_fall  input  1  one-cycle pulse, conditioned SCLK falling edge
cs_n  input  1  conditioned chip select, active low
mosi  input  1  conditioned MOSI level
mem_rdata  input  DATA_W  register-file read data; valid 1 clk after mem_addr changes
mem_addr  output  ADDR_W  registered address from command
mem_wdata  output  DATA_W  registered write data
mem_we  output  1  one-cycle write strobe
miso  output  1  registered serial read data
miso_oe  output  1  MISO tristate enable
frame_done  output  1  one-cycle pulse at end of a completed frame

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; shift register and bit counter 0.
  - Reset mid-frame behaves identically and takes priority over all other inputs.
- States: IDLE, CMD, READ_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE.
- cs_n high in any state:
  - Next state IDLE, counter cleared, miso_oe 0.
  - No mem_we, no frame_done.
  - An aborted write never reaches memory.
- IDLE -> CMD when cs_n low.
- Sampling:
  - MOSI is sampled only on sclk_rise, shifted into the LSB of the shift register.
  - The counter increments per rise.
- CMD -> next state after ADDR_W+1 rises:
  - mem_addr <= upper ADDR_W bits of the command.
  - The last bit selects read (1) or write (0).
  - Read -> READ_ADDR; write -> WRITE_SHIFT.
  - Counter cleared.
- Read path:
  - READ_ADDR holds for exactly 1 clk (memory read latency).
  - READ_LOAD loads mem_rdata into the shift register, sets miso_oe=1, then goes to READ_SHIFT.
  - READ_SHIFT, on each sclk_fall: miso <= shift[DATA_W-1], shift left by 1, counter increments.
  - After the DATA_W-th fall: frame_done pulse, -> DONE.
- Write path:
  - WRITE_SHIFT shifts MOSI on rises.
  - After the DATA_W-th rise -> WRITE_COMMIT.
  - WRITE_COMMIT: mem_wdata <= shift register and mem_we=1 for exactly 1 clk, with frame_done pulsing in the same cycle; then -> DONE.
- DONE:
  - miso_oe 0; all SCLK edges ignored.
  - Leaves only via cs_n high -> IDLE. Extra clocks never wrap into a new frame.
- Edge handling:
  - sclk_fall is ignored outside READ_SHIFT.
  - sclk_rise is ignored in READ_ADDR, READ_LOAD, READ_SHIFT and DONE.
  - If rise and fall are asserted in the same cycle, rise is processed and fall dropped.
- Timing contract:
  - SCLK half-period ≥ 4 clk cycles at the conditioner output.
  - This guarantees READ_LOAD completes before the first data-phase fall.
- Latency:
  - mem_we is asserted 1 clk after the sclk_rise pulse of the last data bit.
  - miso changes 1 clk after each sclk_fall pulse.
- Counter width: $clog2(ADDR_W+2); wraps never, since it is cleared at each phase boundary.

Decomposition:
- Shared package spi_pkg:
  - State enumeration constants.
  - ADDR_W/DATA_W defaults.
  - READ_BIT encoding (1 = read).
- One sub-module: spi_shift_reg (WIDTH param).
  - Inputs: serial-in enable on rise, shift-out enable on fall, parallel load.
  - Outputs: parallel out and MSB.
- Controller FSM and counter stay in spi_frame_ctrl.

Test Plan:
- Write: cs_n low, MOSI command 0x2A+W (bits 0101010_0), data 0xC3 -> one mem_we pulse with mem_addr=0x2A, mem_wdata=0xC3, frame_done same cycle, miso_oe stays 0.
- Read: mem_rdata model returns 0xA5 for addr 0x11; command 0010001_1 -> miso_oe=1 after 8th rise; miso over 8 falls = 1,0,1,0,0,1,0,1; frame_done after 8th fall; miso_oe 0 in DONE.
- Abort: write frame with cs_n raised after 12 rises -> no mem_we, no frame_done, state IDLE, miso_oe 0; next full frame writes correctly.
- Reset mid-read after 3 data falls -> all outputs 0 next cycle; subsequent write of 0x5A to addr 0x7F succeeds.
- Overrun: 20 extra SCLK cycles after a completed write with cs_n still low -> exactly one mem_we total; no second frame_done.
- Back-to-back: write 0x99 to addr 3, cs_n high 1 clk, read addr 3 -> miso shifts out 1,0,0,1,1,0,0,1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame controller: FSM state encoding,
// default widths and the command R/W bit encoding.
package spi_pkg;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 8;

  // Last command bit: 1 selects a read frame, 0 a write frame.
  localparam logic READ_BIT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CMD          = 3'd1,
    ST_READ_ADDR    = 3'd2,
    ST_READ_LOAD    = 3'd3,
    ST_READ_SHIFT   = 3'd4,
    ST_WRITE_SHIFT  = 3'd5,
    ST_WRITE_COMMIT = 3'd6,
    ST_DONE         = 3'd7
  } state_t;

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Bus bundle between the SPI input conditioner / register file and the
// frame controller.
//   slave  : controller view (consumes SCLK edges, CS, MOSI, read data;
//            drives memory port, MISO, MISO enable, frame_done)
//   master : environment view (conditioner + register file)
interface spi_frame_ctrl_if import spi_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_n;
  logic              mosi;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              miso;
  logic              miso_oe;
  logic              frame_done;

  modport slave (
    input  sclk_rise, sclk_fall, cs_n, mosi, mem_rdata,
    output mem_addr, mem_wdata, mem_we, miso, miso_oe, frame_done
  );

  modport master (
    output sclk_rise, sclk_fall, cs_n, mosi, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, miso, miso_oe, frame_done
  );

endinterface

// File: rtl/spi_shift_reg.sv
// Shared serial shift register for command, write data and read data.
//   clk, reset : clock, synchronous active-high reset (clears register)
//   sin_en/sin : shift sin into the LSB
//   sout_en    : shift left by one, zero into the LSB
//   load_en    : parallel load of load_data (highest priority)
//   msb        : register bit WIDTH-1
//   low        : register bits WIDTH-2..0 (together with msb the full word)
module spi_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_en,
  input  logic             sin,
  input  logic             sout_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb,
  output logic [WIDTH-2:0] low
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (sin_en) begin
      q <= {q[WIDTH-2:0], sin};
    end else if (sout_en) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];
  assign low = q[WIDTH-2:0];

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 frame controller: command byte (address MSB-first, then R/W)
// followed by one data byte; drives the register-file port and MISO.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave modport (SCLK edge pulses, CS, MOSI, read data in;
//                mem_addr/mem_wdata/mem_we, miso/miso_oe, frame_done out)
module spi_frame_ctrl import spi_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  spi_frame_ctrl_if.slave bus
);

  localparam int unsigned CMD_W = ADDR_W + 1;
  localparam int unsigned SR_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(SR_W + 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;

  logic              rise_c, fall_c;
  logic              sin_c, sout_c, load_c;
  logic              sr_msb;
  logic [SR_W-2:0]   sr_low;
  logic [SR_W-1:0]   serial_word_c;
  logic [CMD_W-1:0]  cmd_c;
  logic [DATA_W-1:0] wdata_c;
  logic [SR_W-1:0]   load_word_c;

  spi_shift_reg #(.WIDTH(SR_W)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .sin_en    (sin_c),
    .sin       (bus.mosi),
    .sout_en   (sout_c),
    .load_en   (load_c),
    .load_data (load_word_c),
    .msb       (sr_msb),
    .low       (sr_low)
  );

  // Word as it will look once the bit arriving this cycle is shifted in,
  // so the last command/data bit can be decoded on its own rise.
  assign serial_word_c = {sr_low, bus.mosi};
  assign cmd_c         = CMD_W'(serial_word_c);
  assign wdata_c       = DATA_W'(serial_word_c);
  // Read data is left-aligned so it leaves from the register MSB.
  assign load_word_c   = SR_W'(bus.mem_rdata) << (SR_W - DATA_W);

  // Rise wins when both edges arrive together.
  assign rise_c = bus.sclk_rise;
  assign fall_c = bus.sclk_fall & ~bus.sclk_rise;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter and output-next logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    miso_d  = miso_q;
    oe_d    = oe_q;
    sin_c   = 1'b0;
    sout_c  = 1'b0;
    load_c  = 1'b0;

    if (bus.cs_n) begin
      // Deselect aborts any frame; nothing partial is committed.
      state_d = ST_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_d = ST_CMD;
          if (rise_c) begin
            sin_c = 1'b1;
            cnt_d = CNT_W'(1);
          end
        end
        ST_CMD: begin
          if (rise_c) begin
            sin_c = 1'b1;
            if (cnt == CNT_W'(CMD_W - 1)) begin
              cnt_d   = '0;
              addr_d  = cmd_c[CMD_W-1:1];
              state_d = (cmd_c[0] == READ_BIT) ? ST_READ_ADDR : ST_WRITE_SHIFT;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        ST_READ_ADDR: begin
          state_d = ST_READ_LOAD;
        end
        ST_READ_LOAD: begin
          load_c  = 1'b1;
          oe_d    = 1'b1;
          state_d = ST_READ_SHIFT;
        end
        ST_READ_SHIFT: begin
          if (fall_c) begin
            sout_c = 1'b1;
            miso_d = sr_msb;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              oe_d    = 1'b0;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        ST_WRITE_SHIFT: begin
          if (rise_c) begin
            sin_c = 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              // Strobe is visible throughout WRITE_COMMIT.
              cnt_d   = '0;
              wdata_d = wdata_c;
              we_d    = 1'b1;
              done_d  = 1'b1;
              state_d = ST_WRITE_COMMIT;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        ST_WRITE_COMMIT: begin
          state_d = ST_DONE;
        end
        ST_DONE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = we_q;
  assign bus.miso       = miso_q;
  assign bus.miso_oe    = oe_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed frames plus random
// read/write frames compared against a byte-array register-file model.
module tb_spi_frame_ctrl;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_frame_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  spi_frame_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file attached to the DUT: registered read, one cycle latency.
  logic [7:0] mem [128];
  logic       pre_we;
  logic [6:0] pre_addr;
  logic [7:0] pre_data;
  int         we_count = 0;
  int         done_count = 0;
  int         done_we_count = 0;
  int         oe_cycles = 0;
  logic [6:0] last_waddr;
  logic [7:0] last_wdata;

  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.mem_we === 1'b1) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      we_count   <= we_count + 1;
      last_waddr <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
    end
    if (bus.frame_done === 1'b1) done_count <= done_count + 1;
    if (bus.frame_done === 1'b1 && bus.mem_we === 1'b1) done_we_count <= done_we_count + 1;
    if (bus.miso_oe === 1'b1) oe_cycles <= oe_cycles + 1;
  end

  // Reference: what the register file must contain after each frame.
  logic [7:0] model_mem [128];

  int checks = 0;
  int errors = 0;
  int we0, dn0, dw0, oe0;
  logic [7:0] rbits;
  logic       done8, oe8, we16;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    we0 = we_count; dn0 = done_count; dw0 = done_we_count; oe0 = oe_cycles;
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    cyc(1);
    pre_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start();
    bus.cs_n = 1'b0;
    cyc(2);
  endtask

  task automatic stop(input int gap);
    cyc(2);
    bus.cs_n = 1'b1;
    cyc(gap);
  endtask

  // n SCLK periods: rise, >=4 clk high, fall, >=4 clk low. Captures MISO
  // after falls 8..15 (read data phase), frame_done after fall 15,
  // miso_oe just before fall 8 and mem_we one clk after rise 16.
  task automatic clocks(input logic [15:0] bits, input int n,
                        output logic [7:0] rb, output logic d8,
                        output logic o8, output logic w16);
    rb = '0; d8 = 1'b0; o8 = 1'b0; w16 = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i < 16) bus.mosi = bits[15-i];
      else        bus.mosi = 1'($urandom_range(0, 1));
      cyc(1);
      bus.sclk_rise = 1'b1;
      cyc(1);
      bus.sclk_rise = 1'b0;
      if (i == 15) w16 = bus.mem_we;
      cyc(3);
      if (i == 7) o8 = bus.miso_oe;
      bus.sclk_fall = 1'b1;
      cyc(1);
      bus.sclk_fall = 1'b0;
      if (i >= 7 && i <= 14) rb[14-i] = bus.miso;
      if (i == 14) d8 = bus.frame_done;
      cyc(3);
    end
  endtask

  task automatic write_frame(input string tag, input logic [6:0] a, input logic [7:0] d,
                             input int n, input int gap);
    snap();
    start();
    clocks({a, 1'b0, d}, n, rbits, done8, oe8, we16);
    stop(gap);
    chk({tag, "_we_latency"}, 32'(we16), 32'd1);
    chk({tag, "_we_count"},   32'(we_count - we0), 32'd1);
    chk({tag, "_done_w_we"},  32'(done_we_count - dw0), 32'd1);
    chk({tag, "_done_count"}, 32'(done_count - dn0), 32'd1);
    chk({tag, "_addr"},       32'(last_waddr), 32'(a));
    chk({tag, "_data"},       32'(last_wdata), 32'(d));
    chk({tag, "_no_oe"},      32'(oe_cycles - oe0), 32'd0);
    model_mem[a] = d;
  endtask

  task automatic read_frame(input string tag, input logic [6:0] a, input int gap);
    snap();
    start();
    clocks({a, 1'b1, 8'h00}, 16, rbits, done8, oe8, we16);
    chk({tag, "_oe_end"}, 32'(bus.miso_oe), 32'd0);
    stop(gap);
    chk({tag, "_oe_after_cmd"}, 32'(oe8), 32'd1);
    chk({tag, "_miso_bits"},    32'(rbits), 32'(model_mem[a]));
    chk({tag, "_done_8th"},     32'(done8), 32'd1);
    chk({tag, "_done_count"},   32'(done_count - dn0), 32'd1);
    chk({tag, "_no_we"},        32'(we_count - we0), 32'd0);
  endtask

  initial begin
    logic [6:0] ra;
    logic [7:0] rd;
    reset = 1'b1;
    bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.sclk_rise = 1'b0; bus.sclk_fall = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 128; i++) preload(7'(i), 8'h00);
    cyc(2);
    chk("reset_outputs",
        32'({bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.miso, bus.miso_oe, bus.frame_done}), 32'd0);
    reset = 1'b0;
    cyc(2);

    // Basic write and read.
    write_frame("wr_2a", 7'h2A, 8'hC3, 16, 2);
    preload(7'h11, 8'hA5);
    read_frame("rd_11", 7'h11, 2);
    read_frame("rd_2a", 7'h2A, 2);

    // Abort a write after 12 rises: nothing may reach memory.
    snap();
    start();
    clocks({7'h55, 1'b0, 8'h77}, 12, rbits, done8, oe8, we16);
    bus.cs_n = 1'b1;
    cyc(2);
    chk("abort_no_we",   32'(we_count - we0), 32'd0);
    chk("abort_no_done", 32'(done_count - dn0), 32'd0);
    chk("abort_oe",      32'(bus.miso_oe), 32'd0);
    write_frame("wr_after_abort", 7'h55, 8'h77, 16, 2);

    // Reset three falls into a read data phase.
    start();
    clocks({7'h2A, 1'b1, 8'h00}, 10, rbits, done8, oe8, we16);
    chk("rst_read_partial", 32'(rbits[7:5]), 32'h6);
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_outputs",
        32'({bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.miso, bus.miso_oe, bus.frame_done}), 32'd0);
    reset = 1'b0;
    bus.cs_n = 1'b1;
    cyc(2);
    write_frame("wr_7f", 7'h7F, 8'h5A, 16, 2);

    // Overrun: 20 extra SCLK periods after the frame with CS still low.
    write_frame("overrun", 7'h10, 8'h3C, 36, 2);

    // Back-to-back write then read with a 1 clk deselect.
    write_frame("b2b_wr", 7'h03, 8'h99, 16, 1);
    read_frame("b2b_rd", 7'h03, 2);
    read_frame("rd_7f", 7'h7F, 2);

    // Random frames against the model.
    for (int r = 0; r < 24; r++) begin
      ra = 7'($urandom_range(0, 127));
      rd = 8'($urandom);
      if ($urandom_range(0, 1) == 0) write_frame("rnd_wr", ra, rd, 16, 2);
      else                           read_frame("rnd_rd", ra, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
